// File: rtl/main.sv
// ---------------------------------------------------------------------------
// main -- iterative 32-bit ARX block-encryption core (4 rounds, 1 round/clk)
//
// Encrypts the plaintext word {IN_1,IN_2,IN_3,IN_4} with a fixed 4-round
// add-rotate-xor cipher and presents the ciphertext on OUT_1..OUT_4.
//
// Round r on (a,b,c,d):
//   f          = rotl3((a + K[r]) mod 256) ^ b
//   next state = (b, c, d, f)
// with K = {8'h1F, 8'hA7, 8'h3B, 8'hC4}.
//
// Ports
//   CLK        in   1  system clock, rising-edge
//   RST        in   1  synchronous active-high reset (priority over EN)
//   EN         in   1  start request, level-sampled
//   IN_1..4    in   8  plaintext bytes A (MSB) .. D (LSB), sampled on load
//   OUT_1..4   out  8  registered ciphertext bytes A .. D
//   state_dbg  out  2  current FSM state (0=IDLE, 1=ROUND, 2=DONE)
//
// Handshake: EN is a level start request. It is accepted only in IDLE; the
// edge that sees EN=1 in IDLE is the load edge. EN is ignored in ROUND. In
// DONE the core waits for an edge with EN=0 before returning to IDLE, so a
// permanently-high EN yields exactly one encryption. OUT_x change only on the
// final round edge (or reset) and hold the last ciphertext otherwise.
// ---------------------------------------------------------------------------
module main (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic [7:0] IN_1,
  input  logic [7:0] IN_2,
  input  logic [7:0] IN_3,
  input  logic [7:0] IN_4,
  output logic [7:0] OUT_1,
  output logic [7:0] OUT_2,
  output logic [7:0] OUT_3,
  output logic [7:0] OUT_4,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [1:0] r, r_n;
  logic [7:0] a, b, c, d;
  logic [7:0] a_n, b_n, c_n, d_n;
  logic [7:0] out_1_n, out_2_n, out_3_n, out_4_n;

  logic [7:0] round_key;
  logic [7:0] sum;
  logic [7:0] f;

  // Round-key lookup indexed by the round counter.
  always_comb begin
    round_key = 8'h1F;
    case (r)
      2'd0: round_key = 8'h1F;
      2'd1: round_key = 8'hA7;
      2'd2: round_key = 8'h3B;
      2'd3: round_key = 8'hC4;
      default: round_key = 8'h1F;
    endcase
  end

  // 8-bit add wraps naturally; rotate-left-by-3 is pure wiring.
  assign sum = a + round_key;
  assign f   = {sum[4:0], sum[7:5]} ^ b;

  // Next-state and datapath control.
  always_comb begin
    state_n = state;
    r_n     = r;
    a_n     = a;
    b_n     = b;
    c_n     = c;
    d_n     = d;
    out_1_n = OUT_1;
    out_2_n = OUT_2;
    out_3_n = OUT_3;
    out_4_n = OUT_4;

    case (state)
      IDLE: begin
        if (EN) begin
          a_n     = IN_1;
          b_n     = IN_2;
          c_n     = IN_3;
          d_n     = IN_4;
          r_n     = 2'd0;
          state_n = ROUND;
        end
      end
      ROUND: begin
        a_n = b;
        b_n = c;
        c_n = d;
        d_n = f;
        r_n = r + 2'd1;
        if (r == 2'd3) begin
          // Last round: publish ciphertext in the same edge it is formed.
          out_1_n = b;
          out_2_n = c;
          out_3_n = d;
          out_4_n = f;
          state_n = DONE;
        end
      end
      DONE: begin
        if (!EN) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      r     <= 2'd0;
      a     <= 8'h00;
      b     <= 8'h00;
      c     <= 8'h00;
      d     <= 8'h00;
      OUT_1 <= 8'h00;
      OUT_2 <= 8'h00;
      OUT_3 <= 8'h00;
      OUT_4 <= 8'h00;
    end else begin
      state <= state_n;
      r     <= r_n;
      a     <= a_n;
      b     <= b_n;
      c     <= c_n;
      d     <= d_n;
      OUT_1 <= out_1_n;
      OUT_2 <= out_2_n;
      OUT_3 <= out_3_n;
      OUT_4 <= out_4_n;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_main.sv
// ---------------------------------------------------------------------------
// tb_main -- directed self-checking bench for the ARX encryption core.
// Expected ciphertexts were computed by hand from the round definition:
//   (3C,DD,AC,23) -> (07,88,1C,38)
//   (00,00,00,00) -> (F8,3D,D9,DE)
// ---------------------------------------------------------------------------
module tb_main;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [31:0] CT_NOM  = 32'h07881C38;
  localparam logic [31:0] CT_ZERO = 32'hF83DD9DE;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] in_1, in_2, in_3, in_4;
  logic [7:0] out_1, out_2, out_3, out_4;
  logic [1:0] state_dbg;

  int vectors;
  int miscompares;

  // ---------------- clock / reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  main dut (
    .CLK       (clk),
    .RST       (rst),
    .EN        (en),
    .IN_1      (in_1),
    .IN_2      (in_2),
    .IN_3      (in_3),
    .IN_4      (in_4),
    .OUT_1     (out_1),
    .OUT_2     (out_2),
    .OUT_3     (out_3),
    .OUT_4     (out_4),
    .state_dbg (state_dbg)
  );

  // ---------------- driver tasks ----------------
  // Advance one rising edge and settle 1 ns past it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [31:0] w);
    in_1 = w[31:24];
    in_2 = w[23:16];
    in_3 = w[15:8];
    in_4 = w[7:0];
  endtask

  // ---------------- checkers ----------------
  task automatic chk_out(input string tag, input logic [31:0] expected);
    logic [31:0] observed;
    observed = {out_1, out_2, out_3, out_4};
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: OUT observed %08h expected %08h", tag, observed, expected);
    end
  endtask

  task automatic chk_state(input string tag, input logic [1:0] expected);
    vectors++;
    assert (state_dbg === expected) else begin
      miscompares++;
      $error("FAIL %s: state observed %0d expected %0d", tag, state_dbg, expected);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    en  = 1'b1;
    set_in(32'h3CDDAC23);

    // Reset for 2 edges with EN high: nothing loads.
    step();
    step();
    chk_out("reset_out", 32'h0);
    chk_state("reset_state", S_IDLE);
    rst = 1'b0;
    en  = 1'b0;
    step();
    chk_state("idle_after_reset", S_IDLE);
    chk_out("idle_out", 32'h0);

    // Nominal: EN high across 4 edges, then low.
    set_in(32'h3CDDAC23);
    en = 1'b1;
    step();                                   // load edge N
    chk_state("nom_load_state", S_ROUND);
    step();                                   // N+1
    chk_out("nom_hold_r0", 32'h0);
    step();                                   // N+2
    step();                                   // N+3
    chk_out("nom_hold_r2", 32'h0);
    chk_state("nom_round_state", S_ROUND);
    en = 1'b0;
    step();                                   // N+4
    chk_out("nom_result", CT_NOM);
    chk_state("nom_done_state", S_DONE);
    step();
    chk_state("nom_back_idle", S_IDLE);
    chk_out("nom_hold_idle", CT_NOM);

    // All-zero plaintext with a 1-cycle EN pulse.
    set_in(32'h00000000);
    en = 1'b1;
    step();                                   // load
    en = 1'b0;
    step();
    chk_out("zero_hold_1", CT_NOM);
    step();
    chk_out("zero_hold_2", CT_NOM);
    step();
    chk_out("zero_hold_3", CT_NOM);
    step();                                   // load + 4
    chk_out("zero_result", CT_ZERO);
    step();
    chk_state("zero_back_idle", S_IDLE);

    // EN held high: one encryption only.
    set_in(32'h3CDDAC23);
    en = 1'b1;
    repeat (5) step();
    chk_out("hold_en_result", CT_NOM);
    chk_state("hold_en_done", S_DONE);
    set_in(32'h00000000);
    repeat (6) step();
    chk_out("hold_en_no_restart", CT_NOM);
    chk_state("hold_en_still_done", S_DONE);
    en = 1'b0;
    step();
    chk_state("hold_en_drop_idle", S_IDLE);
    en = 1'b1;
    repeat (5) step();
    chk_out("hold_en_second", CT_ZERO);
    en = 1'b0;
    step();
    chk_state("hold_en_idle2", S_IDLE);

    // Inputs change right after load: result unaffected.
    set_in(32'h3CDDAC23);
    en = 1'b1;
    step();
    en = 1'b0;
    set_in(32'hA55A0FF0);
    step();
    set_in({8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))});
    repeat (3) step();
    chk_out("in_change_result", CT_NOM);
    step();
    chk_state("in_change_idle", S_IDLE);

    // Reset on the 2nd round edge aborts the run.
    set_in(32'h00000000);
    en = 1'b1;
    step();                                   // load
    en = 1'b0;
    step();                                   // round 0
    rst = 1'b1;
    step();                                   // would-be round 1
    chk_out("mid_reset_out", 32'h0);
    chk_state("mid_reset_state", S_IDLE);
    rst = 1'b0;
    step();
    chk_state("mid_reset_idle", S_IDLE);
    chk_out("mid_reset_hold", 32'h0);
    set_in(32'h3CDDAC23);
    en = 1'b1;
    step();
    en = 1'b0;
    repeat (3) step();
    chk_out("post_reset_hold", 32'h0);
    step();
    chk_out("post_reset_result", CT_NOM);

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
